// File: rtl/adc_emu_pkg.sv
// Shared types and helpers for the ADC SPI responder model.
// Holds default geometry, frame counter width, FSM states and the test pattern.
package adc_emu_pkg;

    localparam int NUM_CH_D    = 8;
    localparam int SAMPLE_W_D  = 16;
    localparam int FRAME_CNT_W = 13;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    // Internal test pattern: channel number on top, pre-increment frame count below.
    function automatic logic [SAMPLE_W_D-1:0] pattern(
        input logic [2:0]             ch,
        input logic [FRAME_CNT_W-1:0] cnt
    );
        return {ch, cnt};
    endfunction

endpackage

// File: rtl/adc_emu_sync_edge.sv
// Synchronizer for one asynchronous pin plus rise/fall edge pulses.
// Ports: i_clk, i_reset (sync, high), i_async in; o_level, o_rise, o_fall out.
module adc_emu_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
)(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= {STAGES{INIT}};
            r_dly  <= INIT;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_dly <= r_sync[STAGES-1];
        end
    end

    // Pulses come straight from flops so the consumer acts on the next edge.
    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_dly;
    assign o_fall  = ~r_sync[STAGES-1] & r_dly;

endmodule

// File: rtl/adc_spi_responder.sv
// Responder-side model of an 8-channel dual-DOUT SAR ADC for SPI loopback.
// Ports: i_clk, i_reset, i_convst, i_cs_n, i_sclk, i_adc_reset, i_ext_en,
// i_ext_data in; o_busy, o_douta, o_doutb, o_frame_cnt out.
module adc_spi_responder
    import adc_emu_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_D,
    parameter int SAMPLE_W    = SAMPLE_W_D,
    parameter int CONV_CYCLES = 200,
    parameter int SYNC_STAGES = 2
)(
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_convst,
    input  logic                         i_cs_n,
    input  logic                         i_sclk,
    input  logic                         i_adc_reset,
    input  logic                         i_ext_en,
    input  logic [NUM_CH*SAMPLE_W-1:0]   i_ext_data,
    output logic                         o_busy,
    output logic                         o_douta,
    output logic                         o_doutb,
    output logic [FRAME_CNT_W-1:0]       o_frame_cnt
);

    localparam int HALF  = NUM_CH / 2;
    localparam int SH_W  = HALF * SAMPLE_W;
    localparam int BIT_W = $clog2(SH_W) + 1;
    localparam int CNT_W = $clog2(CONV_CYCLES + 1);

    logic w_cv_lvl, w_cv_rise, w_cv_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_arst_lvl, w_arst_rise, w_arst_fall;
    logic w_unused;
    logic w_rst;
    logic w_latch;

    logic [SAMPLE_W-1:0]    w_new [NUM_CH];
    logic [SH_W-1:0]        w_load_a;
    logic [SH_W-1:0]        w_load_b;

    state_t                 r_state;
    logic                   r_busy;
    logic [CNT_W-1:0]       r_cnt;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [SAMPLE_W-1:0]    r_res [NUM_CH];
    logic [SH_W-1:0]        r_sha;
    logic [SH_W-1:0]        r_shb;
    logic [BIT_W-1:0]       r_bits;

    adc_emu_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_cv (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_convst),
        .o_level (w_cv_lvl),
        .o_rise  (w_cv_rise),
        .o_fall  (w_cv_fall)
    );

    adc_emu_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_cs_n),
        .o_level (w_cs_lvl),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    adc_emu_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_sclk),
        .o_level (w_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    adc_emu_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_arst (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_adc_reset),
        .o_level (w_arst_lvl),
        .o_rise  (w_arst_rise),
        .o_fall  (w_arst_fall)
    );

    assign w_unused = ^{w_cv_lvl, w_cv_fall, w_sclk_lvl, w_sclk_rise,
                        w_arst_rise, w_arst_fall};

    // The device reset pin acts on its synchronized level, held while high.
    assign w_rst   = i_reset | w_arst_lvl;
    assign w_latch = (r_state == CONV) && (r_cnt == '0);

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_new[k] = i_ext_en ? i_ext_data[k*SAMPLE_W +: SAMPLE_W]
                                : SAMPLE_W'(pattern(3'(k), r_frame_cnt));
        end
    end

    // A frame opening on the latch cycle must see the fresh results.
    always_comb begin
        w_load_a = '0;
        w_load_b = '0;
        for (int k = 0; k < HALF; k++) begin
            w_load_a[SH_W-1-k*SAMPLE_W -: SAMPLE_W] =
                w_latch ? w_new[k] : r_res[k];
            w_load_b[SH_W-1-k*SAMPLE_W -: SAMPLE_W] =
                w_latch ? w_new[k+HALF] : r_res[k+HALF];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_frame_cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_res[k] <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_cv_rise) begin
                        r_state <= CONV;
                        r_busy  <= 1'b1;
                        r_cnt   <= CNT_W'(CONV_CYCLES - 1);
                    end
                end
                CONV: begin
                    if (w_latch) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        for (int k = 0; k < NUM_CH; k++) begin
                            r_res[k] <= w_new[k];
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_sha  <= '0;
            r_shb  <= '0;
            r_bits <= '0;
        end else if (w_cs_fall) begin
            r_sha  <= w_load_a;
            r_shb  <= w_load_b;
            r_bits <= '0;
        end else if (w_cs_rise) begin
            r_sha  <= '0;
            r_shb  <= '0;
            r_bits <= '0;
        end else if (w_sclk_fall && !w_cs_lvl &&
                     r_bits != BIT_W'(SH_W)) begin
            r_sha  <= r_sha << 1;
            r_shb  <= r_shb << 1;
            r_bits <= r_bits + 1'b1;
        end
    end

    assign o_busy      = r_busy;
    assign o_douta     = r_sha[SH_W-1];
    assign o_doutb     = r_shb[SH_W-1];
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: table of conversions plus
// hand-written retrigger, abort, device-reset and counter-wrap sequences.
module tb_adc_spi_responder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         convst = 1'b0;
    logic         f_convst = 1'b0;
    logic         cs_n = 1'b1;
    logic         sclk = 1'b0;
    logic         adc_reset = 1'b0;
    logic         ext_en = 1'b0;
    logic [127:0] ext_data = '0;

    logic         busy, douta, doutb;
    logic [12:0]  frame_cnt;
    logic         f_busy, f_douta, f_doutb;
    logic [12:0]  f_frame_cnt;

    int n_checks = 0;
    int n_fail = 0;

    logic [63:0] rd_a, rd_b, rd_fa, rd_fb;
    logic        rd_xtra;

    int   busy_rises = 0;
    int   busy_cur = 0;
    int   busy_last = 0;
    logic busy_prev = 1'b0;

    always #5 clk = ~clk;

    adc_spi_responder u_dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_convst    (convst),
        .i_cs_n      (cs_n),
        .i_sclk      (sclk),
        .i_adc_reset (adc_reset),
        .i_ext_en    (ext_en),
        .i_ext_data  (ext_data),
        .o_busy      (busy),
        .o_douta     (douta),
        .o_doutb     (doutb),
        .o_frame_cnt (frame_cnt)
    );

    adc_spi_responder #(.CONV_CYCLES(1)) u_fast (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_convst    (f_convst),
        .i_cs_n      (cs_n),
        .i_sclk      (sclk),
        .i_adc_reset (adc_reset),
        .i_ext_en    (ext_en),
        .i_ext_data  (ext_data),
        .o_busy      (f_busy),
        .o_douta     (f_douta),
        .o_doutb     (f_doutb),
        .o_frame_cnt (f_frame_cnt)
    );

    always @(negedge clk) begin
        if (busy && !busy_prev) begin
            busy_rises = busy_rises + 1;
            busy_cur = 1;
        end else if (busy) begin
            busy_cur = busy_cur + 1;
        end
        if (!busy && busy_prev) busy_last = busy_cur;
        busy_prev = busy;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slow-instance conversion with exact busy latency and width checks.
    task automatic convert_slow();
        int len;
        convst = 1'b1;
        repeat (2) @(negedge clk);
        check("busy_early", 64'(busy), 64'd0);
        @(negedge clk);
        check("busy_rise", 64'(busy), 64'd1);
        convst = 1'b0;
        len = busy ? 1 : 0;
        while (busy && len < 1000) begin
            @(negedge clk);
            if (busy) len++;
        end
        check("busy_len", 64'(len), 64'd200);
        repeat (4) @(negedge clk);
    endtask

    // Master side: sclk idles low, samples on rise, responder shifts on fall.
    task automatic read_frame(input int nbits, input bit keep_cs);
        rd_a = '0; rd_b = '0; rd_fa = '0; rd_fb = '0; rd_xtra = 1'b0;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            if (i < 64) begin
                rd_a  = {rd_a[62:0], douta};
                rd_b  = {rd_b[62:0], doutb};
                rd_fa = {rd_fa[62:0], f_douta};
                rd_fb = {rd_fb[62:0], f_doutb};
            end else begin
                rd_xtra = rd_xtra | douta | doutb | f_douta | f_doutb;
            end
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        if (!keep_cs) begin
            cs_n = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    typedef struct {
        logic         ext_en;
        logic [127:0] ext_data;
        logic [63:0]  exp_a;
        logic [63:0]  exp_b;
        logic [12:0]  exp_cnt;
    } vec_t;

    vec_t vecs [3];

    initial begin
        vecs[0] = '{1'b0, 128'h0,
                    64'h0000_2000_4000_6000, 64'h8000_A000_C000_E000, 13'd1};
        vecs[1] = '{1'b1, 128'h0BAD_F00D_CAFE_BEEF_DEF0_9ABC_5678_1234,
                    64'h1234_5678_9ABC_DEF0, 64'hBEEF_CAFE_F00D_0BAD, 13'd2};
        vecs[2] = '{1'b0, 128'h0,
                    64'h0002_2002_4002_6002, 64'h8002_A002_C002_E002, 13'd3};

        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_douta", 64'(douta), 64'd0);
        check("rst_doutb", 64'(doutb), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);

        for (int v = 0; v < 3; v++) begin
            ext_en = vecs[v].ext_en;
            ext_data = vecs[v].ext_data;
            convert_slow();
            check("vec_frame_cnt", 64'(frame_cnt), 64'(vecs[v].exp_cnt));
            read_frame(66, 1'b0);
            check("vec_douta", rd_a, vecs[v].exp_a);
            check("vec_doutb", rd_b, vecs[v].exp_b);
            check("vec_tail_zero", 64'(rd_xtra), 64'd0);
        end

        // Retrigger mid-conversion, then read while busy.
        ext_en = 1'b0;
        begin
            int rises0;
            rises0 = busy_rises;
            convst = 1'b1;
            repeat (4) @(negedge clk);
            convst = 1'b0;
            repeat (46) @(negedge clk);
            convst = 1'b1;
            repeat (4) @(negedge clk);
            convst = 1'b0;
            check("retrig_busy_mid", 64'(busy), 64'd1);
            read_frame(64, 1'b0);
            check("busy_read_a", rd_a, vecs[2].exp_a);
            check("busy_read_b", rd_b, vecs[2].exp_b);
            check("retrig_rises", 64'(busy_rises - rises0), 64'd1);
            check("retrig_len", 64'(busy_last), 64'd200);
            check("retrig_frame_cnt", 64'(frame_cnt), 64'd4);
        end
        read_frame(64, 1'b0);
        check("post_retrig_a", rd_a, 64'h0003_2003_4003_6003);
        check("post_retrig_b", rd_b, 64'h8003_A003_C003_E003);

        // Aborted frame, stray sclk with cs_n high, then a fresh frame.
        read_frame(10, 1'b1);
        check("abort_partial_a", rd_a, 64'h0000_0000_0000_0000);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_douta", 64'(douta), 64'd0);
        check("abort_doutb", 64'(doutb), 64'd0);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        read_frame(64, 1'b0);
        check("fresh_a", rd_a, 64'h0003_2003_4003_6003);
        check("fresh_b", rd_b, 64'h8003_A003_C003_E003);

        // Device reset pin during a conversion.
        convst = 1'b1;
        repeat (4) @(negedge clk);
        convst = 1'b0;
        repeat (50) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        adc_reset = 1'b1;
        begin
            int k;
            k = 0;
            while (busy && k < 3) begin
                @(negedge clk);
                k++;
            end
        end
        check("adc_reset_busy", 64'(busy), 64'd0);
        check("adc_reset_cnt", 64'(frame_cnt), 64'd0);
        convst = 1'b1;
        repeat (4) @(negedge clk);
        convst = 1'b0;
        repeat (4) @(negedge clk);
        adc_reset = 1'b0;
        repeat (20) @(negedge clk);
        check("convst_in_reset_busy", 64'(busy), 64'd0);
        check("convst_in_reset_cnt", 64'(frame_cnt), 64'd0);
        read_frame(64, 1'b0);
        check("reset_read_a", rd_a, 64'd0);
        check("reset_read_b", rd_b, 64'd0);

        // Frame counter wrap on the short-conversion instance.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8191; i++) begin
            f_convst = 1'b1;
            repeat (2) @(negedge clk);
            f_convst = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("wrap_pre_cnt", 64'(f_frame_cnt), 64'd8191);
        f_convst = 1'b1;
        repeat (2) @(negedge clk);
        f_convst = 1'b0;
        repeat (8) @(negedge clk);
        check("wrap_cnt", 64'(f_frame_cnt), 64'd0);
        read_frame(64, 1'b0);
        check("wrap_a", rd_fa, 64'h1FFF_3FFF_5FFF_7FFF);
        check("wrap_b", rd_fb, 64'h9FFF_BFFF_DFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
